if_fetch_buffer: RTL

- Receiving end of the instruction-fetch output interface: captures each {PC+4, Instruction} pair produced by the fetch stage into a small show-ahead FIFO.
- Presents the head entry to the decode stage. Drives the fetch stage's freeze input when it cannot accept more.
- Discards all buffered entries when a branch is taken.
- Sits between the fetch stage and the decode stage, replacing a plain fetch/decode pipeline register.

---
 rtl/if_fetch_buffer_if.sv | 31 +++
 rtl/if_fetch_buffer.sv | 79 +++++++
 2 files changed

// File: rtl/if_fetch_buffer_if.sv
// Fetch-to-decode buffer bus: fetch-side pair/freeze, decode-side head/ready, flush.
// Latency: none, wires only.
// Backpressure: freeze flows back to fetch, id_ready flows back from decode.
interface if_fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]    PC_in;
  logic [31:0]    Instruction_in;
  logic           in_valid;
  logic           Branch_taken;
  logic           id_ready;
  logic           freeze;
  logic [31:0]    PC_out;
  logic [31:0]    Instruction_out;
  logic           out_valid;
  logic [PTR_W:0] count;

  // Environment side: fetch stage, decode stage and branch unit.
  modport master (
    output PC_in, Instruction_in, in_valid, Branch_taken, id_ready,
    input  freeze, PC_out, Instruction_out, out_valid, count
  );

  // Buffer side.
  modport slave (
    input  PC_in, Instruction_in, in_valid, Branch_taken, id_ready,
    output freeze, PC_out, Instruction_out, out_valid, count
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// Show-ahead FIFO of {PC+4, instruction} pairs between fetch and decode.
// Latency: a pushed pair is visible at the head one cycle after its push edge.
// Backpressure: freeze = full from registered count only; Branch_taken flushes everything.
module if_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  if_fetch_buffer_if.slave  fb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];

  logic full, empty, push, pop;

  // Flags come from registered count only, so freeze has no path from decode or the branch unit.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    push  = fb.in_valid & ~full & ~fb.Branch_taken;
    pop   = ~empty & fb.id_ready & ~fb.Branch_taken;
  end

  // Next-state for pointers and occupancy; a flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fb.Branch_taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  // Storage write: the accepted pair lands at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {fb.PC_in, fb.Instruction_in};
  end

  // Control state, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head is forced to zero when empty so decode sees a clean bubble.
  always_comb begin
    fb.freeze          = full;
    fb.out_valid       = ~empty;
    fb.count           = count_q;
    fb.PC_out          = empty ? 32'h0 : mem_q[rd_ptr_q][63:32];
    fb.Instruction_out = empty ? 32'h0 : mem_q[rd_ptr_q][31:0];
  end
endmodule
